// File: rtl/pp_pipeline_accel_fifo_srl_param_pkg.sv
// Shared types and helpers for the pp_pipeline_accel shift-register FIFO.
// Address-width function, flag bundle, flag compare and flag reset value.
package pp_fifo_pkg;

  typedef struct packed {
    logic full_n;
    logic empty_n;
    logic afull_n;
    logic aempty_n;
  } pp_flags_t;

  localparam pp_flags_t FLAGS_RST = '{
    full_n:   1'b1,
    empty_n:  1'b0,
    afull_n:  1'b1,
    aempty_n: 1'b0
  };

  function automatic int pp_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic pp_flags_t pp_flags(
    input int unsigned cnt,
    input int unsigned depth,
    input int unsigned af,
    input int unsigned ae
  );
    pp_flags_t f;
    f.full_n   = (cnt != depth);
    f.empty_n  = (cnt != 0);
    f.afull_n  = (cnt < af);
    f.aempty_n = (cnt > ae);
    return f;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_srl_param_if.sv
// Write/read stream bundle of the shift-register FIFO.
// slave = FIFO side, master = producer/consumer side.
interface pp_pipeline_accel_fifo_srl_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  if_write;
  logic                  if_write_ce;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full_n;
  logic                  if_read;
  logic                  if_read_ce;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  if_almost_empty_n;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic [ADDR_WIDTH:0]   if_fifo_cap;
  logic                  if_err_clr;
  logic                  if_err_ovf;
  logic                  if_err_udf;

  modport slave (
    input  if_write, if_write_ce, if_din,
    input  if_read, if_read_ce, if_err_clr,
    output if_full_n, if_almost_full_n,
    output if_dout, if_empty_n, if_almost_empty_n,
    output if_num_data_valid, if_fifo_cap,
    output if_err_ovf, if_err_udf
  );

  modport master (
    output if_write, if_write_ce, if_din,
    output if_read, if_read_ce, if_err_clr,
    input  if_full_n, if_almost_full_n,
    input  if_dout, if_empty_n, if_almost_empty_n,
    input  if_num_data_valid, if_fifo_cap,
    input  if_err_ovf, if_err_udf
  );
endinterface

// File: rtl/pp_pipeline_accel_fifo_srl_param_shiftreg.sv
// Reset-less shift array: entry 0 takes new data, older words move up.
// Read port is an addressed tap, so the head sits at index cnt-1.
module pp_pipeline_accel_fifo_srl_param_shiftreg #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      r_mem[0] <= data;
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_mem[i+1] <= r_mem[i];
      end
    end
  end

  assign q = r_mem[a];

endmodule

// File: rtl/pp_pipeline_accel_fifo_srl_param.sv
// Parametrised FWFT shift-register FIFO with registered level flags.
// Sticky ovf/udf flags exist only when PP_FIFO_ERR_FLAGS_EN is defined.
module pp_pipeline_accel_fifo_srl_param
  import pp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input logic clk,
  input logic reset_n,
  pp_pipeline_accel_fifo_srl_param_if.slave s
);

  localparam int ADDR_WIDTH = pp_addr_w(DEPTH);
  localparam int CW         = ADDR_WIDTH + 1;

  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  pp_flags_t             r_flg;
  pp_flags_t             w_flg_next;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_wr_acc = s.if_write & s.if_write_ce & r_flg.full_n;
  assign w_rd_acc = s.if_read & s.if_read_ce & r_flg.empty_n;

  always_comb begin
    w_cnt_next = r_cnt;
    unique case (1'b1)
      (w_wr_acc & ~w_rd_acc): w_cnt_next = r_cnt + 1'b1;
      (w_rd_acc & ~w_wr_acc): w_cnt_next = r_cnt - 1'b1;
      default:                w_cnt_next = r_cnt;
    endcase
  end

  assign w_flg_next = pp_flags(32'(w_cnt_next), DEPTH,
                               AF_THRESH, AE_THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_flg <= FLAGS_RST;
    end else begin
      r_cnt <= w_cnt_next;
      r_flg <= w_flg_next;
    end
  end

  // Modulo wrap makes cnt==DEPTH map onto the top tap.
  assign w_addr = (r_cnt != '0) ?
                  (r_cnt[ADDR_WIDTH-1:0] - 1'b1) : '0;

  pp_pipeline_accel_fifo_srl_param_shiftreg #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sr (
    .clk (clk),
    .data(s.if_din),
    .ce  (w_wr_acc),
    .a   (w_addr),
    .q   (s.if_dout)
  );

  assign s.if_full_n         = r_flg.full_n;
  assign s.if_empty_n        = r_flg.empty_n;
  assign s.if_almost_full_n  = r_flg.afull_n;
  assign s.if_almost_empty_n = r_flg.aempty_n;
  assign s.if_num_data_valid = r_cnt;
  assign s.if_fifo_cap       = CW'(DEPTH);

`ifdef PP_FIFO_ERR_FLAGS_EN
  logic r_ovf;
  logic r_udf;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = s.if_write & s.if_write_ce & ~r_flg.full_n;
  assign w_udf_set = s.if_read & s.if_read_ce & ~r_flg.empty_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set)         r_ovf <= 1'b1;
      else if (s.if_err_clr) r_ovf <= 1'b0;
      if (w_udf_set)         r_udf <= 1'b1;
      else if (s.if_err_clr) r_udf <= 1'b0;
    end
  end

  assign s.if_err_ovf = r_ovf;
  assign s.if_err_udf = r_udf;
`else
  logic w_unused_clr;
  assign w_unused_clr = s.if_err_clr;
  assign s.if_err_ovf = 1'b0;
  assign s.if_err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_srl_param.sv
// Bench: directed DEPTH=3 checks plus scoreboarded random DEPTH=5 stream.
// Error-flag expectations follow PP_FIFO_ERR_FLAGS_EN.
module tb_pp_pipeline_accel_fifo_srl_param;

`ifdef PP_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_fifo_srl_param_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2)) ifa ();
  pp_pipeline_accel_fifo_srl_param_if #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3)) ifb ();

  pp_pipeline_accel_fifo_srl_param #(
    .DATA_WIDTH(32), .DEPTH(3), .AF_THRESH(2), .AE_THRESH(1)
  ) u_a (.clk(clk), .reset_n(rst_n), .s(ifa));

  pp_pipeline_accel_fifo_srl_param #(
    .DATA_WIDTH(8), .DEPTH(5)
  ) u_b (.clk(clk), .reset_n(rst_n), .s(ifb));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv_a(input logic w, input logic wce,
                       input logic [31:0] d, input logic r,
                       input logic rce, input logic clr);
    ifa.if_write    = w;
    ifa.if_write_ce = wce;
    ifa.if_din      = d;
    ifa.if_read     = r;
    ifa.if_read_ce  = rce;
    ifa.if_err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int num,
                       input logic [31:0] dout,
                       input logic fn, input logic en);
    chk({tag, "_num"}, 32'(ifa.if_num_data_valid), 32'(num));
    chk({tag, "_full_n"}, 32'(ifa.if_full_n), 32'(fn));
    chk({tag, "_empty_n"}, 32'(ifa.if_empty_n), 32'(en));
    chk({tag, "_af_n"}, 32'(ifa.if_almost_full_n), 32'(num < 2));
    chk({tag, "_ae_n"}, 32'(ifa.if_almost_empty_n), 32'(num > 1));
    if (en) chk({tag, "_dout"}, ifa.if_dout, dout);
  endtask

  initial begin
    int          mc;
    int          nw;
    logic        w, wce, r, rce, wa, ra;
    logic [7:0]  d;
    logic [7:0]  exp_b;
    logic [7:0]  sb[$];

    {ifa.if_write, ifa.if_write_ce, ifa.if_read} = '0;
    {ifa.if_read_ce, ifa.if_err_clr} = '0;
    ifa.if_din = '0;
    {ifb.if_write, ifb.if_write_ce, ifb.if_read} = '0;
    {ifb.if_read_ce, ifb.if_err_clr} = '0;
    ifb.if_din = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_a("rst", 0, 32'h0, 1'b1, 1'b0);
    chk("rst_cap", 32'(ifa.if_fifo_cap), 32'd3);
    chk("rst_ovf", 32'(ifa.if_err_ovf), 32'd0);
    chk("rst_udf", 32'(ifa.if_err_udf), 32'd0);
    chk("rst_b_cap", 32'(ifb.if_fifo_cap), 32'd5);
    rst_n = 1'b1;

    drv_a(1, 1, 32'hA1, 0, 0, 0);
    chk_a("w1", 1, 32'hA1, 1'b1, 1'b1);
    drv_a(1, 1, 32'hA2, 0, 0, 0);
    chk_a("w2", 2, 32'hA1, 1'b1, 1'b1);
    drv_a(1, 1, 32'hA3, 0, 0, 0);
    chk_a("w3", 3, 32'hA1, 1'b0, 1'b1);

    drv_a(1, 1, 32'hA4, 1, 1, 0);
    chk_a("fullrw", 2, 32'hA2, 1'b1, 1'b1);
    chk("fullrw_ovf", 32'(ifa.if_err_ovf), 32'(ERR_EN));

    drv_a(1, 0, 32'hEE, 1, 0, 0);
    chk_a("noce", 2, 32'hA2, 1'b1, 1'b1);

    drv_a(1, 1, 32'hA5, 1, 1, 0);
    chk_a("midrw", 2, 32'hA3, 1'b1, 1'b1);
    drv_a(0, 0, 32'h0, 1, 1, 0);
    chk_a("rd1", 1, 32'hA5, 1'b1, 1'b1);
    drv_a(0, 0, 32'h0, 1, 1, 0);
    chk_a("rd2", 0, 32'h0, 1'b1, 1'b0);

    drv_a(1, 1, 32'h55, 1, 1, 0);
    chk_a("emptyrw", 1, 32'h55, 1'b1, 1'b1);
    chk("emptyrw_udf", 32'(ifa.if_err_udf), 32'(ERR_EN));
    chk("emptyrw_ovf", 32'(ifa.if_err_ovf), 32'(ERR_EN));
    drv_a(0, 0, 32'h0, 0, 0, 1);
    chk("clr_udf", 32'(ifa.if_err_udf), 32'd0);
    chk("clr_ovf", 32'(ifa.if_err_ovf), 32'd0);

    drv_a(1, 1, 32'h66, 0, 0, 0);
    drv_a(1, 1, 32'h77, 0, 0, 0);
    chk_a("fill", 3, 32'h55, 1'b0, 1'b1);
    drv_a(0, 0, 32'h0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_empty_n", 32'(ifa.if_empty_n), 32'd0);
    chk("arst_full_n", 32'(ifa.if_full_n), 32'd1);
    chk("arst_num", 32'(ifa.if_num_data_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    drv_a(1, 1, 32'h99, 0, 0, 0);
    chk_a("postrst", 1, 32'h99, 1'b1, 1'b1);
    drv_a(0, 0, 32'h0, 0, 0, 0);

    mc = 0;
    nw = 0;
    for (int cyc = 0; cyc < 4000 && nw < 200; cyc++) begin
      chk("b_num", 32'(ifb.if_num_data_valid), 32'(mc));
      chk("b_full_n", 32'(ifb.if_full_n), 32'(mc != 5));
      chk("b_empty_n", 32'(ifb.if_empty_n), 32'(mc != 0));
      chk("b_af_n", 32'(ifb.if_almost_full_n), 32'(mc < 4));
      chk("b_ae_n", 32'(ifb.if_almost_empty_n), 32'(mc > 1));
      w   = ($urandom_range(0, 3) != 0);
      wce = ($urandom_range(0, 7) != 0);
      r   = ($urandom_range(0, 2) != 0);
      rce = ($urandom_range(0, 7) != 0);
      d   = 8'($urandom);
      wa  = w & wce & (mc != 5);
      ra  = r & rce & (mc != 0);
      if (ra) begin
        exp_b = sb.pop_front();
        chk("b_dout", 32'(ifb.if_dout), 32'(exp_b));
      end
      if (wa) begin
        sb.push_back(d);
        nw++;
      end
      mc = mc + int'(wa) - int'(ra);
      ifb.if_write    = w;
      ifb.if_write_ce = wce;
      ifb.if_din      = d;
      ifb.if_read     = r;
      ifb.if_read_ce  = rce;
      @(posedge clk);
      #1;
    end
    chk("b_words", 32'(nw), 32'd200);

    ifb.if_write = 1'b0;
    for (int k = 0; k < 20 && mc > 0; k++) begin
      exp_b = sb.pop_front();
      chk("b_drain", 32'(ifb.if_dout), 32'(exp_b));
      ifb.if_read    = 1'b1;
      ifb.if_read_ce = 1'b1;
      mc--;
      @(posedge clk);
      #1;
    end
    ifb.if_read = 1'b0;
    chk("b_drained", 32'(ifb.if_empty_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_fifo_srl_param.md
Name: pp_pipeline_accel_fifo_srl_param

Overview:
Parametrised shift-register FIFO for pp_pipeline_accel inter-stage streams.
- Generalised in width and depth: any DEPTH ≥ 2, not only powers of two.
- Adds programmable almost-full/almost-empty flags, an exact occupancy count and optional sticky overflow/underflow error flags.
- Output is first-word-fall-through: the head word is valid whenever if_empty_n=1.
- Drop-in between HLS dataflow stages, keeping the ce-qualified read/write handshake.

Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1).
- DEPTH, 3, capacity in words (≥2).
- AF_THRESH, DEPTH-1, if_almost_full_n is low when count ≥ AF_THRESH (range 1..DEPTH).
- AE_THRESH, 1, if_almost_empty_n is low when count ≤ AE_THRESH (range 0..DEPTH-1).
- ADDR_WIDTH, localparam, max(1, clog2(DEPTH)); not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_write  in  1  write request.
- if_write_ce  in  1  write clock-enable qualifier.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = space available.
- if_almost_full_n  out  1  0 = count ≥ AF_THRESH.
- if_read  in  1  read request.
- if_read_ce  in  1  read clock-enable qualifier.
- if_dout  out  DATA_WIDTH  head word; valid when if_empty_n=1.
- if_empty_n  out  1  1 = data available.
- if_almost_empty_n  out  1  0 = count ≤ AE_THRESH.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.
- if_err_clr  in  1  clears sticky error flags.
- if_err_ovf  out  1  sticky: write attempted while full.
- if_err_udf  out  1  sticky: read attempted while empty.

Behaviour:
- State: count register cnt (ADDR_WIDTH+1 bits), DEPTH-entry shift array, registered flags.
- Accept terms:
  - wr_acc = if_write & if_write_ce & if_full_n
  - rd_acc = if_read & if_read_ce & if_empty_n
- Count update:
  - wr_acc & !rd_acc: cnt+1.
  - rd_acc & !wr_acc: cnt-1.
  - Both or neither: cnt unchanged.
- Shift array: shifts on wr_acc only; entry 0 ← if_din, entry i+1 ← entry i. No reset on the array.
- if_dout = array[cnt-1] when cnt>0, else array[0] (don't-care data). Combinational from the registered cnt and array.
- Flags are registered from cnt_next, so they change in the same edge as cnt and are never combinational from inputs:
  - full_n = (cnt_next != DEPTH)
  - empty_n = (cnt_next != 0)
  - almost_full_n = (cnt_next < AF_THRESH)
  - almost_empty_n = (cnt_next > AE_THRESH)
- Latency: a word written at edge N appears on if_dout with if_empty_n=1 after edge N (1 cycle write→read).
- Full + read + write in the same cycle: write rejected (no pass-through), read accepted; cnt goes to DEPTH-1.
- Empty + read + write in the same cycle: read rejected, write accepted; cnt goes to 1.
- Simultaneous accept at 0<cnt<DEPTH: shift happens, cnt held, and if_dout advances to the next-oldest word because indexing is unchanged.
- if_write or if_read without its ce is ignored entirely.
- Reset (async assert, sync-style deassert handled upstream):
  - cnt=0, if_full_n=1, if_empty_n=0, if_almost_empty_n=0.
  - if_almost_full_n=1, if_num_data_valid=0, if_err_ovf=0, if_err_udf=0.
  - Reset mid-stream discards all contents immediately; if_dout is undefined until the next write.
- if_num_data_valid = cnt; if_fifo_cap = DEPTH.

Optional Feature:
PP_FIFO_ERR_FLAGS_EN
- Defined:
  - if_err_ovf is set on if_write & if_write_ce & !if_full_n.
  - if_err_udf is set on if_read & if_read_ce & !if_empty_n.
  - Both are cleared by if_err_clr; set wins over clear in the same cycle.
- Undefined: ports remain; if_err_ovf and if_err_udf are tied 0 and if_err_clr is ignored. No error registers are synthesised.

Decomposition:
- Package pp_fifo_pkg:
  - clog2-based address-width function.
  - Flag-compare helper.
  - Reset-value constants for the flags.
- One sub-module: pp_pipeline_accel_fifo_srl_param_shiftreg.
  - Parameters DATA_WIDTH, DEPTH, ADDR_WIDTH.
  - Ports clk, data, ce, a, q.
  - No reset.

Test Plan:
1. DEPTH=3, AF_THRESH=2, AE_THRESH=1. Reset, then write 0xA1, 0xA2, 0xA3 on consecutive cycles →
   - if_num_data_valid steps 1, 2, 3.
   - if_almost_full_n falls after the 2nd write; if_full_n falls after the 3rd.
   - if_dout=0xA1 throughout.
2. From full, assert write 0xA4 + read in the same cycle → 0xA1 popped, 0xA4 dropped, count=2, if_dout=0xA2, if_full_n=1; with PP_FIFO_ERR_FLAGS_EN, if_err_ovf=1.
3. From empty, read + write 0x55 in the same cycle → count=1, if_empty_n=1 next cycle, if_dout=0x55; with macro, if_err_udf=1; if_err_clr then returns it to 0.
4. DEPTH=5, DATA_WIDTH=8: stream 200 random words with random read/write/ce toggling → output order matches a scoreboard, count never exceeds 5, no full/empty flag glitch.
5. Count=2: write with if_write_ce=0 and read with if_read_ce=0 → count, if_dout and flags unchanged.
6. Count=3: assert reset_n=0 asynchronously mid-cycle → if_empty_n=0, if_full_n=1, if_num_data_valid=0 before the next clk edge; the first write after release reads back correctly.
